fproc_arbiter: RTL
==================

FPROC_ARBITER -- requirements
Module: fproc_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of requesting processor cores (2..16).
REQ-002 SHALL have parameter ID_WIDTH, default 8, width of the fproc function/measurement id.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, width of the fproc result.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before abort.
REQ-005 SHALL have ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
core_req  input  N_CORES  per-core one-cycle request pulse (the core's fproc_out_ready)
core_id  input  N_CORES*ID_WIDTH  per-core request id, slice i = core i, valid with core_req[i]
core_ready  output  N_CORES  per-core one-cycle result-valid pulse (the core's fproc_ready)
core_data  output  DATA_WIDTH  result broadcast to all cores, valid while any core_ready bit is high
fproc_req_valid  output  1  one-cycle request to the shared fproc
fproc_req_id  output  ID_WIDTH  id for fproc_req_valid
fproc_resp_valid  input  1  one-cycle fproc response strobe
fproc_resp_data  input  DATA_WIDTH  response data, valid with fproc_resp_valid
timeout_err  output  1  one-cycle pulse when a request is aborted by timeout
dup_req_err  output  1  sticky flag: a core requested while its request was still pending

Function
REQ-006 SHALL keep per core a pending bit and a latched id; core_req[i] sets pending[i] and captures core_id slice i on the same edge.
REQ-007 SHALL ignore core_req[i] while pending[i]=1 (id unchanged) and set dup_req_err, which stays set until reset.
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, RESPOND.
REQ-009 IDLE: if any pending bit is set, SHALL select the grant round-robin starting at (last_grant+1) mod N_CORES, register grant and last_grant, go to ISSUE; else stay.
REQ-010 ISSUE: SHALL drive fproc_req_valid=1 and fproc_req_id=latched id of grant for exactly this cycle, clear the timeout counter, go to WAIT.
REQ-011 WAIT: on fproc_resp_valid SHALL latch fproc_resp_data and go to RESPOND; otherwise increment the timeout counter.
REQ-012 WAIT: when the counter reaches TIMEOUT_CYCLES without response, SHALL latch data 0, pulse timeout_err for one cycle and go to RESPOND.
REQ-013 RESPOND: SHALL drive core_ready[grant]=1 and core_data=latched data for exactly one cycle, clear pending[grant], go to IDLE.
REQ-014 SHALL ignore fproc_resp_valid in IDLE, ISSUE and RESPOND.
REQ-015 core_ready SHALL be one-hot or zero; core_data SHALL be 0 when core_ready is 0.
REQ-016 A core_req[grant] arriving in the RESPOND cycle SHALL leave pending[grant] set (set wins over clear), with the new id latched.
REQ-017 Minimum latency: core_req in cycle 0, with arbiter in IDLE and no other pending core -> fproc_req_valid in cycle 2; fproc_resp_valid in cycle k (k>=3) -> core_ready in cycle k+1.
REQ-018 Round-robin SHALL guarantee each pending core is granted within N_CORES transactions.
REQ-019 timeout counter SHALL be wide enough for TIMEOUT_CYCLES with no wrap.

Reset
REQ-020 On reset high, asynchronously: state=IDLE, pending=0, latched ids/data=0, grant=0, last_grant=N_CORES-1 (core 0 has first priority), counter=0, dup_req_err=0.
REQ-021 While reset is high, all outputs SHALL be 0; reset mid-transaction SHALL discard all pending requests, and a late fproc_resp_valid after reset SHALL be ignored.

Verification
REQ-022 Single: core_req[2] with id 0x15 cycle 0; resp 0xDEADBEEF cycle 5 -> fproc_req_valid/id 0x15 cycle 2, core_ready=4'b0100, core_data=0xDEADBEEF cycle 6.
REQ-023 Contention: core_req=4'b1111 cycle 0, fproc responds 3 cycles after each request -> grants in order 0,1,2,3, each core_ready exactly once.
REQ-024 Fairness: core 0 re-requests immediately after every response while core 3 pending -> core 3 granted before core 0's second grant.
REQ-025 Timeout: TIMEOUT_CYCLES=8, no response -> timeout_err pulse after 8 WAIT cycles, next cycle core_ready of grant with core_data=0.
REQ-026 Duplicate: core_req[1] twice before response, second with different id -> dup_req_err=1, one fproc request with first id, one core_ready[1].
REQ-027 Reset in WAIT: assert reset, release, then fproc_resp_valid -> no core_ready, state IDLE, pending=0.

Source files
------------

// File: rtl/fproc_arbiter.sv
// Round-robin arbiter sharing one fproc unit among N_CORES requesters.
// One transaction in flight at a time: IDLE -> ISSUE -> WAIT -> RESPOND.
module fproc_arbiter #(
  parameter int N_CORES        = 4,
  parameter int ID_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CORES-1:0]           core_req,
  input  logic [N_CORES*ID_WIDTH-1:0]  core_id,
  output logic [N_CORES-1:0]           core_ready,
  output logic [DATA_WIDTH-1:0]        core_data,
  output logic                         fproc_req_valid,
  output logic [ID_WIDTH-1:0]          fproc_req_id,
  input  logic                         fproc_resp_valid,
  input  logic [DATA_WIDTH-1:0]        fproc_resp_data,
  output logic                         timeout_err,
  output logic                         dup_req_err
);

  localparam int GW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                  state_q, state_d;
  logic [N_CORES-1:0]      pending_q, pending_d;
  logic [ID_WIDTH-1:0]     id_q [N_CORES];
  logic [ID_WIDTH-1:0]     id_d [N_CORES];
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dup_q, dup_d;
  logic [N_CORES-1:0]      clr;
  logic [GW-1:0]           rr_sel, cand;
  logic                    rr_found;

  // Search starts one past the last grant so every pending core is reached within N_CORES grants.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      cand = GW'((int'(last_q) + k) % N_CORES);
      if (!rr_found && pending_q[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    data_d          = data_q;
    clr             = '0;
    fproc_req_valid = 1'b0;
    fproc_req_id    = '0;
    core_ready      = '0;
    core_data       = '0;
    timeout_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_sel;
          last_d  = rr_sel;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fproc_req_valid = 1'b1;
        fproc_req_id    = id_q[grant_q];
        cnt_d           = '0;
        state_d         = WAIT;
      end
      WAIT: begin
        if (fproc_resp_valid) begin
          data_d  = fproc_resp_data;
          state_d = RESPOND;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          data_d      = '0;
          timeout_err = 1'b1;
          state_d     = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: begin
        core_ready[grant_q] = 1'b1;
        core_data           = data_q;
        clr[grant_q]        = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new request from the core being answered is accepted in the same cycle (set beats clear).
  always_comb begin
    pending_d = pending_q;
    dup_d     = dup_q;
    for (int i = 0; i < N_CORES; i++) begin
      id_d[i] = id_q[i];
      if (core_req[i] && (!pending_q[i] || clr[i])) begin
        pending_d[i] = 1'b1;
        id_d[i]      = core_id[i*ID_WIDTH +: ID_WIDTH];
      end else begin
        if (clr[i]) pending_d[i] = 1'b0;
        if (core_req[i]) dup_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
      grant_q   <= '0;
      last_q    <= GW'(N_CORES - 1);
      cnt_q     <= '0;
      dup_q     <= 1'b0;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      dup_q     <= dup_d;
      for (int i = 0; i < N_CORES; i++) id_q[i] <= id_d[i];
    end
  end

  assign dup_req_err = dup_q;

endmodule
